// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side bundle for the ultrasonic ranger: control/echo in, trigger and result out.
interface ultrasonic_ranger_if;
  logic       enable;
  logic       echo;
  logic       trig;
  logic [7:0] distance_inches;
  logic       valid;
  logic       timeout;
  logic       busy;

  modport master (output enable, echo,
                  input  trig, distance_inches, valid, timeout, busy);
  modport slave  (input  enable, echo,
                  output trig, distance_inches, valid, timeout, busy);
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing, width-to-inches conversion.
module ultrasonic_ranger #(
  parameter int CLKS_PER_US    = 48,
  parameter int TRIG_US        = 10,
  parameter int US_PER_INCH    = 148,
  parameter int MEAS_PERIOD_US = 60000
) (
  input  logic          clk,
  input  logic          reset,
  ultrasonic_ranger_if.slave bus
);
  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int SUB_W = (US_PER_INCH > 1) ? $clog2(US_PER_INCH) : 1;
  localparam int PER_W = $clog2(MEAS_PERIOD_US + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD} state_t;

  state_t             state, state_next;
  logic               echo_meta, echo_sync, echo_prev;
  logic [PRE_W-1:0]   pre;
  logic [PER_W-1:0]   period_us;
  logic [SUB_W-1:0]   sub;
  logic [7:0]         inch_cnt, inch_inc, inch_now;
  logic [7:0]         distance, dist_val;
  logic               valid, timeout;
  logic               load, to_strobe;
  logic               us_tick, rise, fall, period_done, trig_done, sub_wrap;

  assign rise        = echo_sync & ~echo_prev;
  assign fall        = ~echo_sync & echo_prev;
  assign us_tick     = (pre == PRE_W'(CLKS_PER_US - 1));
  assign period_done = (period_us == PER_W'(MEAS_PERIOD_US));
  assign trig_done   = us_tick && (period_us == PER_W'(TRIG_US - 1));
  assign sub_wrap    = us_tick && (sub == SUB_W'(US_PER_INCH - 1));
  assign inch_inc    = (inch_cnt == 8'd255) ? 8'd255 : inch_cnt + 8'd1;
  // The tick landing in the falling-edge cycle still counts toward the result.
  assign inch_now    = sub_wrap ? inch_inc : inch_cnt;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    to_strobe  = 1'b0;
    dist_val   = inch_now;
    case (state)
      IDLE:      if (bus.enable) state_next = TRIG;
      TRIG:      if (trig_done) state_next = WAIT_ECHO;
      WAIT_ECHO: begin
        if (period_done) begin
          load       = 1'b1;
          to_strobe  = 1'b1;
          dist_val   = 8'd255;
          state_next = bus.enable ? TRIG : IDLE;
        end else if (rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        // A completed echo wins over a coincident period expiry.
        if (fall) begin
          load       = 1'b1;
          state_next = HOLD;
        end else if (period_done) begin
          load       = 1'b1;
          to_strobe  = 1'b1;
          dist_val   = 8'd255;
          state_next = bus.enable ? TRIG : IDLE;
        end
      end
      HOLD:      if (period_done) state_next = bus.enable ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
      pre       <= '0;
      period_us <= '0;
      sub       <= '0;
      inch_cnt  <= '0;
      distance  <= 8'd255;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      echo_meta <= bus.echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
      pre       <= (state_next != state || us_tick) ? '0 : pre + PRE_W'(1);

      if (state_next == TRIG && state != TRIG)
        period_us <= '0;
      else if (us_tick && period_us != '1)
        period_us <= period_us + PER_W'(1);

      if (state_next == MEASURE && state != MEASURE) begin
        sub      <= '0;
        inch_cnt <= '0;
      end else if (state == MEASURE && us_tick) begin
        if (sub_wrap) begin
          sub      <= '0;
          inch_cnt <= inch_inc;
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end

      valid   <= load;
      timeout <= to_strobe;
      if (load) distance <= dist_val;
    end
  end

  assign bus.trig            = (state == TRIG);
  assign bus.busy            = (state != IDLE);
  assign bus.valid           = valid;
  assign bus.timeout         = timeout;
  assign bus.distance_inches = distance;
endmodule
